// File: rtl/instr_encoder.sv
// RV32IMF instruction encoder: packs decoded fields back into a 32-bit word.
// Stage 1 classifies the opcode and range-checks the immediate; stage 2 packs
// the word. Unencodable bundles come out as a canonical NOP with out_err set.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_R = 3'd5;
  localparam logic [2:0] FMT_X = 3'd6;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Goes high on the first clock after reset so in_ready is low while in reset.
  logic ready_q;

  logic        s1_valid_q;
  logic        s1_err_q;
  logic [2:0]  s1_fmt_q;
  logic [6:0]  s1_opcode_q;
  logic [4:0]  s1_rd_q;
  logic [4:0]  s1_rs1_q;
  logic [4:0]  s1_rs2_q;
  logic [2:0]  s1_funct3_q;
  logic [6:0]  s1_funct7_q;
  logic [31:0] s1_imm_q;

  logic        s2_valid_q;
  logic [31:0] s2_instr_q;
  logic        s2_err_q;

  logic [CNT_W-1:0] enc_count_q;
  logic [CNT_W-1:0] err_count_q;

  logic        s1_adv;
  logic        in_fire;
  logic        out_fire;
  logic [2:0]  fmt_d;
  logic        imm_ok;
  logic [31:0] pack_w;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = ready_q && (!s1_valid_q || s1_adv);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

  // Classify the incoming opcode and check the immediate fits its format.
  always_comb begin
    fmt_d  = FMT_X;
    imm_ok = 1'b0;
    case (in_opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0000111: begin
        fmt_d  = FMT_I;
        imm_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
      end
      7'b0100011, 7'b0100111: begin
        fmt_d  = FMT_S;
        imm_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
      end
      7'b1100011: begin
        fmt_d  = FMT_B;
        imm_ok = !in_imm[0] && ((&in_imm[31:12]) || !(|in_imm[31:12]));
      end
      7'b0110111, 7'b0010111: begin
        fmt_d  = FMT_U;
        imm_ok = !(|in_imm[11:0]);
      end
      7'b1101111: begin
        fmt_d  = FMT_J;
        imm_ok = !in_imm[0] && ((&in_imm[31:20]) || !(|in_imm[31:20]));
      end
      7'b0110011, 7'b1010011: begin
        fmt_d  = FMT_R;
        imm_ok = 1'b1;
      end
      default: begin
        fmt_d  = FMT_X;
        imm_ok = 1'b0;
      end
    endcase
  end

  // Pack the stage-1 fields into the RV32 bit layout of their format.
  always_comb begin
    pack_w = NOP;
    case (s1_fmt_q)
      FMT_I: pack_w = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FMT_S: pack_w = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                       s1_imm_q[4:0], s1_opcode_q};
      FMT_B: pack_w = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                       s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
      FMT_U: pack_w = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
      FMT_J: pack_w = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                       s1_rd_q, s1_opcode_q};
      FMT_R: pack_w = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      default: pack_w = NOP;
    endcase
    if (s1_err_q) begin
      pack_w = NOP;
    end
  end

  // Post-reset ready enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  // Stage 1: capture a bundle with its format and legality verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_fmt_q    <= FMT_X;
      s1_opcode_q <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_funct3_q <= '0;
      s1_funct7_q <= '0;
      s1_imm_q    <= '0;
    end else if (in_fire) begin
      s1_valid_q  <= 1'b1;
      s1_err_q    <= !imm_ok;
      s1_fmt_q    <= fmt_d;
      s1_opcode_q <= in_opcode;
      s1_rd_q     <= in_rd;
      s1_rs1_q    <= in_rs1;
      s1_rs2_q    <= in_rs2;
      s1_funct3_q <= in_funct3;
      s1_funct7_q <= in_funct7;
      s1_imm_q    <= in_imm;
    end else if (s1_adv) begin
      s1_valid_q  <= 1'b0;
    end
  end

  // Stage 2: output register, held stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_q <= pack_w;
        s2_err_q   <= s1_err_q;
      end
    end
  end

  // Saturating delivery statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_count_q <= '0;
      err_count_q <= '0;
    end else if (out_fire) begin
      if (enc_count_q != '1) enc_count_q <= enc_count_q + 1'b1;
      if (s2_err_q && (err_count_q != '1)) err_count_q <= err_count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// traffic compared against a behavioural encoding model and a FIFO scoreboard.
module tb_instr_encoder;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd, in_rs1, in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count, err_count;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  int          n_xfer   = 0;
  int          n_errx   = 0;
  bit          mon_en   = 0;
  bit          last_acc = 0;

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference: format by opcode, legality by signed numeric range, standard RV32 layout.
  function automatic logic [32:0] ref_encode(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                             logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                                             logic [31:0] imm);
    int signed v;
    bit bad;
    logic [31:0] w;
    v = $signed(imm);
    bad = 0;
    w = 32'h0;
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0000111: begin
        bad = (v < -2048) || (v > 2047);
        w = {imm[11:0], rs1, f3, rd, op};
      end
      7'b0100011, 7'b0100111: begin
        bad = (v < -2048) || (v > 2047);
        w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      end
      7'b1100011: begin
        bad = (v % 2 != 0) || (v < -4096) || (v > 4095);
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      7'b0110111, 7'b0010111: begin
        bad = (imm % 32'd4096) != 0;
        w = {imm[31:12], rd, op};
      end
      7'b1101111: begin
        bad = (v % 2 != 0) || (v < -1048576) || (v > 1048575);
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      7'b0110011, 7'b1010011: begin
        w = {f7, rs2, rs1, f3, rd, op};
      end
      default: bad = 1;
    endcase
    if (bad) return {1'b1, 32'h0000_0013};
    return {1'b0, w};
  endfunction

  function automatic int sat(int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  // One clock: sample handshakes on the falling edge, return just after the rising edge.
  task automatic tick();
    logic [32:0] e;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (mon_en) begin
      checks++;
      if (enc_count !== CNT_W'(sat(n_xfer))) begin
        errors++;
        $display("FAIL enc_count got=%0d want=%0d", enc_count, sat(n_xfer));
      end
      checks++;
      if (err_count !== CNT_W'(sat(n_errx))) begin
        errors++;
        $display("FAIL err_count got=%0d want=%0d", err_count, sat(n_errx));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%h", out_instr);
        end else begin
          e = exp_q.pop_front();
          if ({out_err, out_instr} !== e) begin
            errors++;
            $display("FAIL scoreboard got err=%b instr=%h want err=%b instr=%h",
                     out_err, out_instr, e[32], e[31:0]);
          end
          if (e[32]) n_errx++;
        end
        n_xfer++;
      end
      if (last_acc)
        exp_q.push_back(ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic v, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                        logic [2:0] f3, logic [6:0] f7, logic [31:0] imm);
    in_valid = v; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic send_wait(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                           logic [2:0] f3, logic [6:0] f7, logic [31:0] imm, int max_cyc);
    int k;
    set_in(1'b1, op, rd, rs1, rs2, f3, f7, imm);
    k = 0;
    last_acc = 0;
    while (!last_acc && k < max_cyc) begin
      tick();
      k++;
    end
    in_valid = 1'b0;
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=not_accepted want=accepted");
    end
  endtask

  task automatic drain(int max_cyc);
    int k;
    in_valid = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < max_cyc) begin
      tick();
      k++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d want pending=0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    mon_en = 0;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    n_xfer = 0;
    n_errx = 0;
  endtask

  task automatic test_reset();
    set_in(1'b0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0);
    out_ready = 1'b1;
    rst = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got=%h want=0", out_instr); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%b want=0", out_err); end
    checks++; if (enc_count !== '0 || err_count !== '0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d want=0/0", enc_count, err_count);
    end
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_addi_latency();
    do_reset();
    out_ready = 1'b1;
    set_in(1'b1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_early_valid got=%b want=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got=%b want=1", out_valid); end
    checks++; if (out_instr !== 32'hFFF0_0093 || out_err !== 1'b0) begin
      errors++; $display("FAIL addi_word got=%h err=%b want=fff00093 err=0", out_instr, out_err);
    end
    tick();
    checks++; if (out_valid !== 1'b0 || enc_count !== 4'd1) begin
      errors++; $display("FAIL addi_after got valid=%b cnt=%0d want valid=0 cnt=1", out_valid, enc_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  op[4]  = '{7'b0010011, 7'b1100011, 7'b1101111, 7'b0110111};
    logic [4:0]  rd[4]  = '{5'd1, 5'd0, 5'd0, 5'd5};
    logic [4:0]  rs1[4] = '{5'd0, 5'd1, 5'd0, 5'd0};
    logic [4:0]  rs2[4] = '{5'd0, 5'd2, 5'd0, 5'd0};
    logic [31:0] imm[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0800, 32'h1234_5000};
    logic [31:0] ew[4]  = '{32'hFFF0_0093, 32'hFE20_8EE3, 32'h0010_006F, 32'h1234_52B7};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        set_in(1'b1, op[i], rd[i], rs1[i], rs2[i], 3'd0, 7'd0, imm[i]);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%b want=1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_instr !== ew[i-2] || out_err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_word[%0d] got v=%b %h e=%b want v=1 %h e=0", i-2, out_valid, out_instr, out_err, ew[i-2]);
        end
      end
      tick();
    end
    checks++; if (enc_count !== 4'd4) begin errors++; $display("FAIL b2b_count got=%0d want=4", enc_count); end
  endtask

  task automatic test_illegal();
    logic [6:0]  op[4]  = '{7'b0010011, 7'b1100011, 7'b0110111, 7'b0000000};
    logic [31:0] imm[4] = '{32'd2048, 32'd3, 32'h1234_5001, 32'd0};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_in(1'b1, op[i], 5'd3, 5'd4, 5'd5, 3'd2, 7'd0, imm[i]);
      else in_valid = 1'b0;
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h0000_0013 || out_err !== 1'b1) begin
          errors++;
          $display("FAIL illegal[%0d] got v=%b %h e=%b want v=1 00000013 e=1", i-2, out_valid, out_instr, out_err);
        end
      end
      if (i == 3) begin
        checks++; if (err_count !== 4'd1) begin errors++; $display("FAIL illegal_first_errcnt got=%0d want=1", err_count); end
      end
      tick();
    end
    checks++; if (err_count !== 4'd4 || enc_count !== 4'd4) begin
      errors++; $display("FAIL illegal_counts got=%0d/%0d want=4/4", enc_count, err_count);
    end
  endtask

  task automatic test_boundaries();
    logic [6:0]  op[13]  = '{7'b0010011, 7'b0010011, 7'b0100011, 7'b1100011, 7'b1100011, 7'b1101111,
                             7'b1101111, 7'b0110111, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0010011,
                             7'b0110011};
    logic [31:0] imm[13] = '{32'd2047, 32'hFFFF_F800, 32'hFFFF_F800, 32'hFFFF_F000, 32'd4094, 32'd1048574,
                             32'hFFF0_0000, 32'hFFFF_F000, 32'd2048, 32'd4096, 32'd1048576, 32'hFFFF_F7FF,
                             32'hDEAD_BEEF};
    do_reset();
    mon_en = 1;
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++)
      send_wait(op[i], 5'(i), 5'(i + 7), 5'(i + 13), 3'(i), 7'(i * 9), imm[i], 10);
    drain(20);
    mon_en = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    do_reset();
    mon_en = 1;
    out_ready = 1'b0;
    send_wait(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5, 4);
    send_wait(7'b0100011, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 32'hFFFF_FFF0, 4);
    set_in(1'b1, 7'b0110011, 5'd9, 5'd10, 5'd11, 3'd4, 7'h20, 32'h0);
    held = out_instr;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
      checks++; if (out_valid !== 1'b1 || out_instr !== held) begin
        errors++; $display("FAIL bp_stable got v=%b %h want v=1 %h", out_valid, out_instr, held);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (!last_acc) begin errors++; $display("FAIL bp_third_accept got=0 want=1"); end
    in_valid = 1'b0;
    drain(10);
    checks++; if (enc_count !== 4'd3) begin errors++; $display("FAIL bp_enc_count got=%0d want=3", enc_count); end
    mon_en = 0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    out_ready = 1'b1;
    send_wait(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 4);
    send_wait(7'b0000000, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 4);
    tick(); tick();
    out_ready = 1'b0;
    send_wait(7'b0110111, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, 4);
    send_wait(7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1111_1000, 4);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_full got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got=%b want=0", out_valid); end
    checks++; if (enc_count !== '0 || err_count !== '0) begin
      errors++; $display("FAIL mid_async_counts got=%0d/%0d want=0/0", enc_count, err_count);
    end
    do_reset();
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got=%b want=0", out_valid); end
    set_in(1'b1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_early got=%b want=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'hFFF0_0093 || out_err !== 1'b0) begin
      errors++; $display("FAIL mid_post_word got v=%b %h e=%b want v=1 fff00093 e=0", out_valid, out_instr, out_err);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    mon_en = 1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++)
      send_wait(7'b0000000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 4);
    drain(10);
    checks++; if (enc_count !== 4'd15 || err_count !== 4'd15) begin
      errors++; $display("FAIL saturation got=%0d/%0d want=15/15", enc_count, err_count);
    end
    mon_en = 0;
  endtask

  task automatic test_random();
    logic [6:0] ops[12] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0000111, 7'b0100011, 7'b0100111,
                            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1010011};
    logic [31:0] r, imm;
    logic [6:0]  op;
    do_reset();
    mon_en = 1;
    for (int c = 0; c < 400; c++) begin
      r = $urandom();
      case ($urandom_range(0, 3))
        0: imm = r;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = {r[19:0], 12'h000};
        default: imm = {{11{r[20]}}, r[20:1], 1'b0};
      endcase
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom()) : ops[$urandom_range(0, 11)];
      r = $urandom();
      set_in($urandom_range(0, 9) < 7, op, r[4:0], r[9:5], r[14:10], r[17:15], r[24:18], imm);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain(20);
    mon_en = 0;
  endtask

  initial begin
    test_reset();
    test_addi_latency();
    test_back_to_back();
    test_illegal();
    test_boundaries();
    test_backpressure();
    test_reset_midflight();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
